// File: rtl/violet_pkg.sv
// Shared definitions for the UART command deframer and its consumers.
//   frame_state_t : byte-framing FSM states (F_CSUM only used with CMD_CHECKSUM_EN)
//   rx_state_t    : bit-level UART receiver states
//   FRAME_BYTES   : bytes per command frame (3, or 4 with CMD_CHECKSUM_EN)
//   CMD_LEDS/CMD_BTN : command addresses understood by the register block
package violet_pkg;

  typedef enum logic [1:0] {
    F_ADDR = 2'd0,
    F_DLO  = 2'd1,
    F_DHI  = 2'd2,
    F_CSUM = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_BYTES = 4;
`else
  localparam int FRAME_BYTES = 3;
`endif

  localparam logic [7:0] CMD_LEDS = 8'd1;
  localparam logic [7:0] CMD_BTN  = 8'd2;

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 UART receiver with input synchroniser.
// Ports:
//   i_clk      : system clock
//   rst        : synchronous, active-low reset
//   uart_rx    : asynchronous serial line, idle high, LSB first
//   byte_valid : one-cycle pulse, rx_byte holds a byte with a good stop bit
//   byte_err   : one-cycle pulse, the stop bit was sampled low
//   rx_byte    : last assembled byte (holds between pulses)
//   rx_state   : current receiver state (debug / observability)
// Parameter BAUD_DIV: clock cycles per bit, even and >= 4.
// Output handshake: byte_valid/byte_err are strobes with no back-pressure;
// rx_byte is stable in the cycle either strobe is high.
module uart_rx_byte
  import violet_pkg::*;
#(
  parameter int BAUD_DIV = 128
) (
  input  logic      i_clk,
  input  logic      rst,
  input  logic      uart_rx,
  output logic      byte_valid,
  output logic      byte_err,
  output logic [7:0] rx_byte,
  output rx_state_t rx_state
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] HALF_LAST = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BAUD_DIV - 1);

  logic rx_meta, rx_sync;

  rx_state_t       state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shift, shift_n;
  logic            valid_n, err_n;

  // Two-flop synchroniser; reset to the idle level so a reset never fakes a start bit.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state      <= RX_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      byte_valid <= valid_n;
      byte_err   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      RX_IDLE: begin
        timer_n = '0;
        if (!rx_sync) state_n = RX_START;
      end
      RX_START: begin
        // Re-check the line mid start bit; a short low pulse is dropped silently.
        if (timer == HALF_LAST) begin
          timer_n   = '0;
          bit_cnt_n = '0;
          state_n   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      RX_DATA: begin
        if (timer == BIT_LAST) begin
          timer_n = '0;
          shift_n = {rx_sync, shift[7:1]};
          if (bit_cnt == 3'd7) state_n = RX_STOP;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      RX_STOP: begin
        if (timer == BIT_LAST) begin
          timer_n = '0;
          state_n = RX_IDLE;
          if (rx_sync) valid_n = 1'b1;
          else         err_n   = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        state_n = RX_IDLE;
        timer_n = '0;
      end
    endcase
  end

  assign rx_byte  = shift;
  assign rx_state = state;

endmodule

// File: rtl/uart_cmd_deframer.sv
// UART command deframer: assembles addr, data_lo, data_hi bytes into one
// command for the LED/button register block.
// Ports:
//   i_clk     : system clock
//   rst       : synchronous, active-low reset
//   uart_rx   : asynchronous serial input, idle high, 8N1, LSB first
//   cmd_en    : one-cycle strobe, cmd_addr/cmd_data carry a new command
//   cmd_addr  : command address, holds until the next cmd_en
//   cmd_data  : {data_hi, data_lo}, holds until the next cmd_en
//   frame_err : one-cycle strobe on a bad stop bit, timeout or checksum miss
// Handshake: cmd_en is a strobe with no back-pressure; the consumer must take
// cmd_addr/cmd_data in the cycle cmd_en is high. cmd_en and frame_err are
// never high together.
// Build option: define CMD_CHECKSUM_EN to require a 4th byte equal to
// addr ^ data_lo ^ data_hi before a command is issued.
module uart_cmd_deframer
  import violet_pkg::*;
#(
  parameter int BAUD_DIV     = 128,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        cmd_en,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_BITS * BAUD_DIV + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_BITS * BAUD_DIV);

  logic       byte_valid, byte_err;
  logic [7:0] rx_byte;
  rx_state_t  rx_state;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .i_clk      (i_clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .rx_byte    (rx_byte),
    .rx_state   (rx_state)
  );

  frame_state_t    f_state, f_state_n;
  logic [7:0]      addr_sh, addr_sh_n;
  logic [7:0]      dlo_sh, dlo_sh_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            cmd_en_n, frame_err_n;
  logic [7:0]      cmd_addr_n;
  logic [15:0]     cmd_data_n;
  logic            rx_busy;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]      dhi_sh, dhi_sh_n;
`endif

  // The timeout measures idle line time between bytes, so it is held at zero
  // while the receiver is in the middle of a byte.
  assign rx_busy = (rx_state != RX_IDLE);

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      f_state   <= F_ADDR;
      addr_sh   <= '0;
      dlo_sh    <= '0;
      to_cnt    <= '0;
      cmd_en    <= 1'b0;
      frame_err <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
`ifdef CMD_CHECKSUM_EN
      dhi_sh    <= '0;
`endif
    end else begin
      f_state   <= f_state_n;
      addr_sh   <= addr_sh_n;
      dlo_sh    <= dlo_sh_n;
      to_cnt    <= to_cnt_n;
      cmd_en    <= cmd_en_n;
      frame_err <= frame_err_n;
      cmd_addr  <= cmd_addr_n;
      cmd_data  <= cmd_data_n;
`ifdef CMD_CHECKSUM_EN
      dhi_sh    <= dhi_sh_n;
`endif
    end
  end

  always_comb begin
    f_state_n   = f_state;
    addr_sh_n   = addr_sh;
    dlo_sh_n    = dlo_sh;
    to_cnt_n    = to_cnt;
    cmd_en_n    = 1'b0;
    frame_err_n = 1'b0;
    cmd_addr_n  = cmd_addr;
    cmd_data_n  = cmd_data;
`ifdef CMD_CHECKSUM_EN
    dhi_sh_n    = dhi_sh;
`endif
    // Byte events take priority over the timeout, so a byte landing on the
    // expiry cycle is kept and the counter restarts.
    if (byte_err) begin
      frame_err_n = 1'b1;
      f_state_n   = F_ADDR;
      to_cnt_n    = '0;
    end else if (byte_valid) begin
      to_cnt_n = '0;
      case (f_state)
        F_ADDR: begin
          addr_sh_n = rx_byte;
          f_state_n = F_DLO;
        end
        F_DLO: begin
          dlo_sh_n  = rx_byte;
          f_state_n = F_DHI;
        end
`ifdef CMD_CHECKSUM_EN
        F_DHI: begin
          dhi_sh_n  = rx_byte;
          f_state_n = F_CSUM;
        end
        F_CSUM: begin
          if (rx_byte == (addr_sh ^ dlo_sh ^ dhi_sh)) begin
            cmd_en_n   = 1'b1;
            cmd_addr_n = addr_sh;
            cmd_data_n = {dhi_sh, dlo_sh};
          end else begin
            frame_err_n = 1'b1;
          end
          f_state_n = F_ADDR;
        end
`else
        F_DHI: begin
          cmd_en_n   = 1'b1;
          cmd_addr_n = addr_sh;
          cmd_data_n = {rx_byte, dlo_sh};
          f_state_n  = F_ADDR;
        end
`endif
        default: begin
          f_state_n = F_ADDR;
        end
      endcase
    end else if (f_state == F_ADDR || rx_busy) begin
      to_cnt_n = '0;
    end else if (to_cnt == TO_LIMIT) begin
      frame_err_n = 1'b1;
      f_state_n   = F_ADDR;
      to_cnt_n    = '0;
    end else begin
      to_cnt_n = to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Bench for uart_cmd_deframer (BAUD_DIV=16, TIMEOUT_BITS=4). A reference model
// works at frame level: it collects bytes into a frame queue and, for every
// complete frame, bad stop bit or over-long mid-frame gap, pushes the expected
// {frame_err, cmd_addr, cmd_data} into exp_q. A forked monitor pops exp_q on
// every cmd_en/frame_err strobe. Define CMD_CHECKSUM_EN for the 4-byte build.
module tb_uart_cmd_deframer;

  localparam int BAUD_DIV     = 16;
  localparam int TIMEOUT_BITS = 4;
  localparam int TO_CYC       = TIMEOUT_BITS * BAUD_DIV;
`ifdef CMD_CHECKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic        i_clk;
  logic        rst;
  logic        uart_rx;
  logic        cmd_en;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        frame_err;

  uart_cmd_deframer #(
    .BAUD_DIV     (BAUD_DIV),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .i_clk     (i_clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .cmd_en    (cmd_en),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .frame_err (frame_err)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [24:0] exp_q[$];
  logic [7:0]  frm_q[$];
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  int          checks = 0;
  int          errors = 0;
  int          err_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] csum(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
    return a ^ lo ^ hi;
  endfunction

  task automatic model_reset();
    frm_q.delete();
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      frm_q.delete();
      exp_q.push_back({1'b1, m_addr, m_data});
    end else begin
      frm_q.push_back(b);
      if (frm_q.size() == FB) begin
        if (FB == 4 && frm_q[FB-1] != csum(frm_q[0], frm_q[1], frm_q[2])) begin
          exp_q.push_back({1'b1, m_addr, m_data});
        end else begin
          m_addr = frm_q[0];
          m_data = {frm_q[2], frm_q[1]};
          exp_q.push_back({1'b0, m_addr, m_data});
        end
        frm_q.delete();
      end
    end
  endtask

  // Gaps used by the bench are either <= 2 bit-times or > TIMEOUT_BITS.
  task automatic model_idle(input int bits);
    if (bits > TIMEOUT_BITS && frm_q.size() != 0) begin
      frm_q.delete();
      exp_q.push_back({1'b1, m_addr, m_data});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    drive_bit(1'b0, BAUD_DIV);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BAUD_DIV);
    if (stop_ok) begin
      drive_bit(1'b1, BAUD_DIV);
    end else begin
      // Low only across the stop sample point so the line is clearly idle after.
      drive_bit(1'b0, BAUD_DIV / 2 + 4);
      drive_bit(1'b1, BAUD_DIV / 2 - 4);
    end
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    send_byte(b, stop_ok);
  endtask

  task automatic tx_idle(input int bits);
    model_idle(bits);
    drive_bit(1'b1, bits * BAUD_DIV);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
    tx_byte(a, 1'b1);
    tx_byte(lo, 1'b1);
    tx_byte(hi, 1'b1);
    if (FB == 4) tx_byte(csum(a, lo, hi), 1'b1);
  endtask

  task automatic check_hold(input string name);
    check({name, "_addr"}, 32'(cmd_addr), 32'(m_addr));
    check({name, "_data"}, 32'(cmd_data), 32'(m_data));
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [24:0] e, g;
    forever begin
      @(negedge i_clk);
      if (rst && (cmd_en || frame_err)) begin
        check("strobe_exclusive", 32'(cmd_en & frame_err), 32'd0);
        g = {frame_err, cmd_addr, cmd_data};
        if (frame_err) err_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got=%h exp=none", g);
        end else begin
          e = exp_q.pop_front();
          check("strobe_event", 32'(g), 32'(e));
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] fb[4];
  int kind, pos, t0, lat, wait_cyc;
  bit done;

  initial begin
    uart_rx = 1'b1;
    rst     = 1'b0;
    model_reset();
    fork
      monitor();
    join_none
    repeat (3) @(negedge i_clk);
    check("reset_cmd_en", 32'(cmd_en), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_cmd_addr", 32'(cmd_addr), 32'd0);
    check("reset_cmd_data", 32'(cmd_data), 32'd0);
    rst = 1'b1;
    drive_bit(1'b1, 2 * BAUD_DIV);

    // Basic command, then outputs hold.
    send_frame(8'h01, 8'h34, 8'h12);
    tx_idle(2);
    check_hold("hold_after_cmd");

    // Bad stop bit mid-frame, then a clean frame.
    tx_byte(8'h02, 1'b1);
    tx_byte(8'hAA, 1'b0);
    tx_idle(1);
    send_frame(8'h02, 8'hCD, 8'hAB);
    tx_idle(1);

    // Inter-byte timeout and its latency from the end of the byte.
    tx_byte(8'h01, 1'b1);
    tx_byte(8'h55, 1'b1);
    t0 = cyc;
    err_cyc = 0;
    tx_idle(TIMEOUT_BITS + 1);
    lat = err_cyc - t0;
    checks++;
    if (lat < TO_CYC - 12 || lat > TO_CYC + 4) begin
      errors++;
      $display("FAIL timeout_latency got=%0d exp=%0d..%0d", lat, TO_CYC - 12, TO_CYC + 4);
    end
    send_frame(8'h02, 8'h11, 8'h22);
    tx_idle(1);

    // Short low glitch: ignored, framing stays aligned.
    drive_bit(1'b0, 5);
    tx_idle(2);
    send_frame(8'h01, 8'h5A, 8'hC3);
    tx_idle(1);

    // Reset mid-frame discards partial data and clears outputs.
    tx_byte(8'h02, 1'b1);
    tx_byte(8'h77, 1'b1);
    @(negedge i_clk);
    rst = 1'b0;
    @(negedge i_clk);
    model_reset();
    check("midreset_cmd_addr", 32'(cmd_addr), 32'd0);
    check("midreset_cmd_data", 32'(cmd_data), 32'd0);
    rst = 1'b1;
    drive_bit(1'b1, BAUD_DIV);
    send_frame(8'h01, 8'h02, 8'h03);
    tx_idle(1);

`ifdef CMD_CHECKSUM_EN
    tx_byte(8'h01, 1'b1);
    tx_byte(8'h34, 1'b1);
    tx_byte(8'h12, 1'b1);
    tx_byte(8'h27, 1'b1);
    tx_idle(1);
    tx_byte(8'h01, 1'b1);
    tx_byte(8'h34, 1'b1);
    tx_byte(8'h12, 1'b1);
    tx_byte(8'h28, 1'b1);
    tx_idle(1);
`endif

    // Randomised frames: clean, bad stop, long mid-frame gap, bad checksum.
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 7);
      pos  = $urandom_range(0, FB - 1);
      fb[0] = 8'($urandom_range(0, 255));
      fb[1] = 8'($urandom_range(0, 255));
      fb[2] = 8'($urandom_range(0, 255));
      fb[3] = csum(fb[0], fb[1], fb[2]);
      if (kind == 2) fb[3] = fb[3] ^ 8'h5A;
      done = 1'b0;
      for (int i = 0; i < FB && !done; i++) begin
        if (kind == 0 && i == pos) begin
          tx_byte(fb[i], 1'b0);
          tx_idle(1);
          done = 1'b1;
        end else begin
          tx_byte(fb[i], 1'b1);
          if (kind == 1 && i == pos && i < FB - 1) begin
            tx_idle(TIMEOUT_BITS + 2);
            done = 1'b1;
          end else begin
            tx_idle($urandom_range(0, 2));
          end
        end
      end
    end
    tx_idle(2);
    check_hold("hold_final");

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 500) begin
      @(negedge i_clk);
      wait_cyc++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_deframer.md
Name: uart_cmd_deframer

Overview:
- Upstream command source for the LED/button register block: receives UART bytes on uart_rx and assembles 3-byte frames (addr, data_lo, data_hi) into one command.
- Emits a one-cycle cmd_en strobe with cmd_addr/cmd_data, which the register block consumes directly.
- Contains the bit-level UART receiver plus the byte-framing FSM with inter-byte timeout resynchronisation.

Parameters:
- BAUD_DIV, 128, i_clk cycles per UART bit; must be an even number ≥ 4.
- TIMEOUT_BITS, 32, idle bit-times allowed between bytes of one frame before the partial frame is discarded.

Ports:
- i_clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- uart_rx  input  1  asynchronous serial input, idle high, 8N1, LSB first
- cmd_en  output  1  one-cycle pulse; a complete valid command is presented
- cmd_addr  output  8  command address; holds until the next cmd_en
- cmd_data  output  16  command data {data_hi, data_lo}; holds until the next cmd_en
- frame_err  output  1  one-cycle pulse on a bad stop bit or timeout discard

Behaviour:
- Reset (rst=0 at a clock edge): cmd_en=0, frame_err=0, cmd_addr=0, cmd_data=0. Receiver goes to RX_IDLE and the framer to F_ADDR. Synchroniser flops are set to 1. A reset mid-byte or mid-frame discards all partial data.
- uart_rx passes through a 2-flop synchroniser. All sampling uses the synchronised signal.
- Receiver states:
  - RX_IDLE: wait for the synchronised line to be 0.
  - RX_START: count BAUD_DIV/2 cycles, then sample. If 1, treat as a glitch and return to RX_IDLE with no error. If 0, go to RX_DATA.
  - RX_DATA: sample every BAUD_DIV cycles, 8 bits, shifting in LSB first.
  - RX_STOP: sample after BAUD_DIV cycles. If 1, pulse byte_valid with the byte. If 0, pulse byte_err. Then go to RX_IDLE.
- Framer states:
  - F_ADDR: on byte_valid, latch the address into a shadow register and go to F_DLO.
  - F_DLO: on byte_valid, latch data_lo and go to F_DHI.
  - F_DHI: on byte_valid, go to F_ADDR.
- Command output: cmd_addr and cmd_data update, and cmd_en pulses, in the cycle after F_DHI accepts data_hi. Latency from the sample point of the final stop bit to cmd_en is 2 cycles.
- byte_err in any framer state: pulse frame_err and return to F_ADDR. cmd_en is not asserted.
- Timeout: a counter clears on each byte_valid while the framer is not in F_ADDR. When it reaches TIMEOUT_BITS*BAUD_DIV, pulse frame_err and return to F_ADDR. The counter is inactive in F_ADDR.
- If byte_valid and timeout expiry fall in the same cycle, byte_valid wins and the counter clears.
- cmd_en and frame_err are never high in the same cycle.
- There is no back-pressure: the consumer must accept cmd_en in one cycle. Back-to-back frames with zero idle time between them are supported.
- Counter widths: $clog2(BAUD_DIV) bits for the bit timer and $clog2(TIMEOUT_BITS*BAUD_DIV+1) bits for the timeout counter. No counter wraps silently; each saturates or clears explicitly.

Optional Feature:
- Macro CMD_CHECKSUM_EN.
- When defined: F_DHI goes to F_CSUM. F_CSUM expects a 4th byte equal to addr ^ data_lo ^ data_hi.
  - Match: cmd_en pulses as described above.
  - Mismatch: frame_err pulses, the outputs are unchanged, and the framer returns to F_ADDR.
  - The timeout also covers F_CSUM.
- When undefined: there is no F_CSUM state and no checksum logic, and frames are 3 bytes.

Decomposition:
- Package violet_pkg holds:
  - the framer state enum (F_ADDR, F_DLO, F_DHI, F_CSUM);
  - the receiver state enum;
  - FRAME_BYTES (3, or 4 with checksum);
  - the CMD_LEDS=8'd1 and CMD_BTN=8'd2 address constants shared with the consumer.
- Sub-module uart_rx_byte contains the synchroniser and the bit-level receiver. It outputs byte_valid, byte_err and byte[7:0]. The framer, timeout and output registers stay in the top level.

Test Plan (BAUD_DIV=16, TIMEOUT_BITS=4):
- Send 0x01,0x34,0x12 → exactly one cmd_en, with cmd_addr=0x01 and cmd_data=0x1234; the outputs hold afterwards.
- Send 0x02 then 0xAA with stop bit forced to 0 → frame_err pulse, no cmd_en. Follow with 0x02,0xCD,0xAB → cmd_data=0xABCD.
- Send 0x01,0x55, then idle for 5 bit-times → frame_err pulse at 64 cycles after the byte. Next 0x02,0x11,0x22 → cmd_addr=0x02, cmd_data=0x2211.
- Apply a 5-cycle low glitch on uart_rx → no byte, no frame_err, framer stays in F_ADDR.
- Drive rst=0 for 1 cycle after the 2nd byte of a frame → all outputs 0. Remaining bytes 0x01,0x02,0x03 → cmd_addr=0x01, cmd_data=0x0302.
- With CMD_CHECKSUM_EN: frame 0x01,0x34,0x12,0x27 → cmd_en. Same frame ending 0x28 → frame_err, outputs unchanged.
